// File: rtl/stream_fifo_buf_pkg.sv
// Shared definitions for the stream elastic buffer: width helper, default
// payload width and the {sop,eop,data} storage word layout.
package stream_fifo_buf_pkg;

  localparam int unsigned STREAM_DW = 26;

  // Ceiling log2 for elaboration-time width calculation; returns 0 for v <= 1.
  function automatic int unsigned sf_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Storage word is {sop, eop, data}: total width data width + 2.
  function automatic int unsigned word_width(input int unsigned dw);
    return dw + 2;
  endfunction

  function automatic int unsigned eop_bit(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned sop_bit(input int unsigned dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Register-array storage for the stream buffer: one synchronous write port,
// one asynchronous read port. Contents are intentionally not reset.
module stream_fifo_ram
  import stream_fifo_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = word_width(STREAM_DW),
  localparam int unsigned AW = sf_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: capture the incoming word at the write pointer.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo_buf.sv
// Elastic valid/ready buffer of DEPTH beats with sop/eop sidebands,
// occupancy/almost-full reporting and synchronous flush. Ready depends only
// on registered state and rst/flush, so no combinational ready path crosses.
module stream_fifo_buf
  import stream_fifo_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = STREAM_DW,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_THRESH = 3,
  localparam int unsigned LW = sf_clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [LW-1:0]         level,
  output logic                  almost_full
);

  localparam int unsigned PW      = sf_clog2(DEPTH);
  localparam int unsigned WW      = word_width(DATA_WIDTH);
  localparam int unsigned SOP_POS = sop_bit(DATA_WIDTH);
  localparam int unsigned EOP_POS = eop_bit(DATA_WIDTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [WW-1:0] wr_word;
  logic [WW-1:0] rd_word;
  logic          active;
  logic          push;
  logic          pop;

  assign active      = ~rst & ~flush;
  assign in_ready    = active & (level != LW'(DEPTH));
  assign out_valid   = active & (level != LW'(0));
  assign almost_full = active & (level >= LW'(AFULL_THRESH));

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign wr_word = {in_sop, in_eop, in_data};

  stream_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_word),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  // Head is presented straight from storage (first-word-fall-through).
  assign out_data = rd_word[DATA_WIDTH-1:0];
  assign out_sop  = rd_word[SOP_POS];
  assign out_eop  = rd_word[EOP_POS];

  // Pointer and occupancy tracking; reset and flush clear identically.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule
